// File: rtl/pig_turn_controller.sv
// pig_turn_controller: two-player dice game turn sequencer (roll, hold, bust, win)
//   CLK, RESET (sync active-low), NEW_GAME (level clear), ROLL/HOLD (edge actions), LFSR (random sample)
//   DIE, TURN_SUM, P1_SCORE, P2_SCORE, ACTIVE, BUSY, P1, P2: registered game state for the display decoders
module pig_turn_controller #(
  parameter int WIN_SCORE = 100,
  parameter int BUST_HOLD = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       NEW_GAME,
  input  logic       ROLL,
  input  logic       HOLD,
  input  logic [6:0] LFSR,
  output logic [2:0] DIE,
  output logic [6:0] TURN_SUM,
  output logic [6:0] P1_SCORE,
  output logic [6:0] P2_SCORE,
  output logic       ACTIVE,
  output logic       BUSY,
  output logic       P1,
  output logic       P2
);
  typedef enum logic [1:0] {PLAY, BUST, OVER} state_t;
  localparam logic [7:0] WIN = 8'(WIN_SCORE);
  localparam logic [7:0] BH = 8'(BUST_HOLD - 1);
  state_t state, state_n;
  logic roll_d, hold_d, roll_e, hold_e;
  logic [2:0] die, die_n, roll_v;
  logic [6:0] sum, sum_n, s1, s1_n, s2, s2_n, banked;
  logic act, act_n, w1, w1_n, w2, w2_n;
  logic [7:0] cnt, cnt_n, acc, total;
  assign roll_e = ROLL && !roll_d;
  assign hold_e = HOLD && !hold_d;
  assign roll_v = 3'(LFSR % 7'd6) + 3'd1;
  assign acc = {1'b0, sum} + {5'b0, roll_v};
  // bank total is 8 bits wide so a 99 + 99 hold still compares correctly against the win threshold
  assign total = {1'b0, act ? s2 : s1} + {1'b0, sum};
  assign banked = total > 8'd99 ? 7'd99 : total[6:0];
  always_comb begin
    state_n = state;
    die_n = die;
    sum_n = sum;
    s1_n = s1;
    s2_n = s2;
    act_n = act;
    w1_n = w1;
    w2_n = w2;
    cnt_n = cnt;
    if (NEW_GAME) begin
      state_n = PLAY;
      die_n = '0;
      sum_n = '0;
      s1_n = '0;
      s2_n = '0;
      act_n = 1'b0;
      w1_n = 1'b0;
      w2_n = 1'b0;
      cnt_n = '0;
    end else if (state == BUST) begin
      cnt_n = cnt == '0 ? '0 : cnt - 8'd1;
      state_n = cnt == '0 ? PLAY : BUST;
      act_n = cnt == '0 ? !act : act;
    end else if (state == PLAY && hold_e) begin
      sum_n = '0;
      s1_n = act ? s1 : banked;
      s2_n = act ? banked : s2;
      if (total >= WIN) begin
        state_n = OVER;
        w1_n = !act;
        w2_n = act;
      end else
        act_n = !act;
    end else if (state == PLAY && roll_e) begin
      die_n = roll_v;
      if (roll_v == 3'd1) begin
        sum_n = '0;
        state_n = BUST;
        cnt_n = BH;
      end else
        sum_n = acc > 8'd99 ? 7'd99 : acc[6:0];
    end
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= PLAY;
      die <= '0;
      sum <= '0;
      s1 <= '0;
      s2 <= '0;
      act <= 1'b0;
      w1 <= 1'b0;
      w2 <= 1'b0;
      cnt <= '0;
      roll_d <= 1'b1;
      hold_d <= 1'b1;
    end else begin
      state <= state_n;
      die <= die_n;
      sum <= sum_n;
      s1 <= s1_n;
      s2 <= s2_n;
      act <= act_n;
      w1 <= w1_n;
      w2 <= w2_n;
      cnt <= cnt_n;
      roll_d <= ROLL;
      hold_d <= HOLD;
    end
  end
  assign DIE = die;
  assign TURN_SUM = sum;
  assign P1_SCORE = s1;
  assign P2_SCORE = s2;
  assign ACTIVE = act;
  assign BUSY = state == BUST;
  assign P1 = w1;
  assign P2 = w2;
endmodule

// File: tb/tb_pig_turn_controller.sv
// tb_pig_turn_controller: two parameterisations checked against a behavioural game model
module tb_pig_turn_controller;
  logic clk = 0, rst = 0, new_game = 0, roll = 1, hold = 1;
  logic [6:0] lfsr = '0;
  logic [2:0] die_o [2];
  logic [6:0] sum_o [2], s1_o [2], s2_o [2];
  logic act_o [2], busy_o [2], p1_o [2], p2_o [2];
  int total = 0, bad = 0;
  int win_p [2] = '{100, 10};
  int bh_p [2] = '{4, 2};
  int m_die [2], m_sum [2], m_act [2], m_ph [2], m_bl [2];
  int m_sc [2][2], m_w [2][2];
  bit rp = 1, hp = 1, go = 0;
  always #5 clk = ~clk;
  pig_turn_controller #(.WIN_SCORE(100), .BUST_HOLD(4)) dut_a (
    .CLK(clk), .RESET(rst), .NEW_GAME(new_game), .ROLL(roll), .HOLD(hold), .LFSR(lfsr),
    .DIE(die_o[0]), .TURN_SUM(sum_o[0]), .P1_SCORE(s1_o[0]), .P2_SCORE(s2_o[0]),
    .ACTIVE(act_o[0]), .BUSY(busy_o[0]), .P1(p1_o[0]), .P2(p2_o[0]));
  pig_turn_controller #(.WIN_SCORE(10), .BUST_HOLD(2)) dut_b (
    .CLK(clk), .RESET(rst), .NEW_GAME(new_game), .ROLL(roll), .HOLD(hold), .LFSR(lfsr),
    .DIE(die_o[1]), .TURN_SUM(sum_o[1]), .P1_SCORE(s1_o[1]), .P2_SCORE(s2_o[1]),
    .ACTIVE(act_o[1]), .BUSY(busy_o[1]), .P1(p1_o[1]), .P2(p2_o[1]));
  task automatic cmp(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, a, e, $time);
    end
  endtask
  // model phases: 0 playing, 1 bust (m_bl busy cycles left), 2 game over
  task automatic model();
    bit re, he;
    int d, t;
    re = roll && !rp;
    he = hold && !hp;
    rp = rst ? roll : 1'b1;
    hp = rst ? hold : 1'b1;
    if (!rst) go = 1;
    for (int k = 0; k < 2; k++)
      if (!rst || new_game) begin
        m_die[k] = 0; m_sum[k] = 0; m_act[k] = 0; m_ph[k] = 0; m_bl[k] = 0;
        m_sc[k][0] = 0; m_sc[k][1] = 0; m_w[k][0] = 0; m_w[k][1] = 0;
      end else if (m_ph[k] == 1) begin
        m_bl[k]--;
        if (m_bl[k] == 0) begin m_act[k] ^= 1; m_ph[k] = 0; end
      end else if (m_ph[k] == 0) begin
        if (he) begin
          t = m_sc[k][m_act[k]] + m_sum[k];
          m_sc[k][m_act[k]] = t > 99 ? 99 : t;
          m_sum[k] = 0;
          if (t >= win_p[k]) begin m_w[k][m_act[k]] = 1; m_ph[k] = 2; end
          else m_act[k] ^= 1;
        end else if (re) begin
          d = int'(lfsr) % 6 + 1;
          m_die[k] = d;
          if (d == 1) begin m_sum[k] = 0; m_ph[k] = 1; m_bl[k] = bh_p[k]; end
          else m_sum[k] = m_sum[k] + d > 99 ? 99 : m_sum[k] + d;
        end
      end
  endtask
  always @(negedge clk)
    if (go)
      for (int k = 0; k < 2; k++) begin
        cmp($sformatf("die%0d", k), die_o[k], m_die[k]);
        cmp($sformatf("sum%0d", k), sum_o[k], m_sum[k]);
        cmp($sformatf("p1score%0d", k), s1_o[k], m_sc[k][0]);
        cmp($sformatf("p2score%0d", k), s2_o[k], m_sc[k][1]);
        cmp($sformatf("active%0d", k), act_o[k], m_act[k]);
        cmp($sformatf("busy%0d", k), busy_o[k], m_ph[k] == 1);
        cmp($sformatf("p1win%0d", k), p1_o[k], m_w[k][0]);
        cmp($sformatf("p2win%0d", k), p2_o[k], m_w[k][1]);
      end
  task automatic tick();
    @(posedge clk);
    model();
    @(negedge clk);
  endtask
  task automatic press(input int v);
    lfsr = 7'(v);
    roll = 1;
    tick();
    roll = 0;
    tick();
  endtask
  task automatic bank();
    hold = 1;
    tick();
    hold = 0;
    tick();
  endtask
  initial begin
    tick();
    tick();
    cmp("reset_die", die_o[0], 0);
    cmp("reset_score", s1_o[0], 0);
    rst = 1;
    repeat (3) tick();
    cmp("held_at_release", die_o[0], 0);
    roll = 0;
    hold = 0;
    tick();
    lfsr = 127;
    roll = 1;
    tick();
    cmp("single_die", die_o[0], 2);
    cmp("single_sum", sum_o[0], 2);
    repeat (300) tick();
    cmp("no_second_roll", sum_o[0], 2);
    roll = 0;
    tick();
    press(4);
    bank();
    cmp("bank_die", die_o[0], 5);
    cmp("bank_p1", s1_o[0], 7);
    cmp("bank_sum", sum_o[0], 0);
    cmp("bank_active", act_o[0], 1);
    repeat (4) press(127);
    cmp("p2_sum", sum_o[0], 8);
    lfsr = 6;
    roll = 1;
    tick();
    cmp("bust_die", die_o[0], 1);
    cmp("bust_sum", sum_o[0], 0);
    cmp("bust_busy1", busy_o[0], 1);
    roll = 0;
    tick();
    lfsr = 127;
    roll = 1;
    tick();
    roll = 0;
    tick();
    cmp("bust_busy4", busy_o[0], 1);
    tick();
    cmp("bust_end", busy_o[0], 0);
    cmp("bust_active", act_o[0], 0);
    cmp("bust_p2", s2_o[0], 0);
    cmp("bust_die_kept", die_o[0], 1);
    new_game = 1;
    tick();
    new_game = 0;
    tick();
    press(5);
    press(5);
    bank();
    cmp("win_p1score", s1_o[1], 12);
    cmp("win_flag", p1_o[1], 1);
    cmp("win_other", p2_o[1], 0);
    cmp("nowin_a", act_o[0], 1);
    press(127);
    bank();
    cmp("freeze_die", die_o[1], 6);
    cmp("freeze_sum", sum_o[1], 0);
    new_game = 1;
    roll = 1;
    repeat (5) tick();
    roll = 0;
    repeat (5) tick();
    new_game = 0;
    tick();
    cmp("clear_die", die_o[1], 0);
    cmp("clear_score", s1_o[1], 0);
    cmp("clear_win", p1_o[1], 0);
    repeat (15) press(5);
    press(4);
    bank();
    cmp("p1_95", s1_o[0], 95);
    bank();
    press(5);
    press(3);
    cmp("pre_sum", sum_o[0], 10);
    lfsr = 127;
    roll = 1;
    hold = 1;
    tick();
    roll = 0;
    hold = 0;
    tick();
    cmp("clamp_score", s1_o[0], 99);
    cmp("clamp_win", p1_o[0], 1);
    cmp("clamp_die", die_o[0], 4);
    new_game = 1;
    tick();
    new_game = 0;
    lfsr = 6;
    roll = 1;
    tick();
    roll = 0;
    tick();
    cmp("mid_busy", busy_o[0], 1);
    rst = 0;
    tick();
    rst = 1;
    cmp("rst_busy", busy_o[0], 0);
    cmp("rst_die", die_o[0], 0);
    tick();
    press(127);
    cmp("after_rst_die", die_o[0], 2);
    cmp("after_rst_sum", sum_o[0], 2);
    cmp("after_rst_active", act_o[0], 0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) != 0;
      new_game = $urandom_range(0, 149) == 0;
      roll = $urandom_range(0, 2) == 0;
      hold = $urandom_range(0, 11) == 0;
      lfsr = 7'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
